// File: rtl/tl_phase_ctrl.sv
// tl_phase_ctrl: N-approach traffic-light phase controller.
// Rotates green among N_DIR approaches with green -> yellow -> all-red phases
// timed in 1-second ticks derived from a clk prescaler. It also provides a
// seconds countdown, a hold (freeze) input and a flashing-yellow night mode.
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   rst_n       in   asynchronous active-low reset
//   hold        in   1 = freeze prescaler, countdown, phase and flash toggle
//   night_mode  in   request flashing-yellow mode (sampled at all-red end / flash ticks)
//   red         out  per-approach red lamp    (registered)
//   yellow      out  per-approach yellow lamp (registered)
//   green       out  per-approach green lamp  (registered)
//   active_dir  out  approach owning the current/next green
//   remaining   out  seconds left in the current phase (0 in flash mode)
//   phase_done  out  1-cycle pulse on every phase transition
module tl_phase_ctrl #(
    parameter int unsigned N_DIR    = 2,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned TICK_DIV = 50,
    parameter int unsigned GREEN_T  = 30,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned ALLRED_T = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hold,
    input  logic                       night_mode,
    output logic [N_DIR-1:0]           red,
    output logic [N_DIR-1:0]           yellow,
    output logic [N_DIR-1:0]           green,
    output logic [$clog2(N_DIR)-1:0]   active_dir,
    output logic [CNT_W-1:0]           remaining,
    output logic                       phase_done
);

    localparam int unsigned DIR_W = $clog2(N_DIR);
    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam int unsigned MAX_T = (CNT_W >= 1 && CNT_W <= 31) ? ((1 << CNT_W) - 1) : 0;

    // Reject parameter sets the counters cannot represent.
    if (N_DIR < 2 || N_DIR > 8) begin : g_bad_ndir
        $error("tl_phase_ctrl: N_DIR must be 2..8");
    end
    if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cntw
        $error("tl_phase_ctrl: CNT_W must be 1..31");
    end
    if (TICK_DIV < 2) begin : g_bad_div
        $error("tl_phase_ctrl: TICK_DIV must be >= 2");
    end
    if (GREEN_T < 1 || GREEN_T > MAX_T || YELLOW_T < 1 || YELLOW_T > MAX_T ||
        ALLRED_T < 1 || ALLRED_T > MAX_T) begin : g_bad_dur
        $error("tl_phase_ctrl: durations must be 1..2^CNT_W-1");
    end

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FLASH  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [DIR_W-1:0]   dir_q, dir_d;
    logic               flash_q, flash_d;
    logic               done_q, done_d;
    logic [N_DIR-1:0]   red_q, red_d;
    logic [N_DIR-1:0]   yellow_q, yellow_d;
    logic [N_DIR-1:0]   green_q, green_d;
    logic               tick_c;
    logic [DIR_W-1:0]   dir_inc_c;
    logic [N_DIR-1:0]   dir_onehot_c;

    // 1-second tick: last prescaler count while not held.
    assign tick_c = !hold && (pre_q == PRE_W'(TICK_DIV - 1));

    // Modulo-N_DIR increment of the green owner.
    assign dir_inc_c = (dir_q == DIR_W'(N_DIR - 1)) ? '0 : dir_q + DIR_W'(1);

    // Prescaler freezes under hold so it resumes from the same count.
    always_comb begin
        pre_d = pre_q;
        if (!hold) begin
            pre_d = (pre_q == PRE_W'(TICK_DIV - 1)) ? '0 : pre_q + PRE_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ALLRED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: countdown, phase sequencing, direction rotation, flash toggle.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        flash_d = flash_q;
        done_d  = 1'b0;
        if (tick_c) begin
            case (state_q)
                ST_GREEN: begin
                    if (rem_q > CNT_W'(1)) begin
                        rem_d = rem_q - CNT_W'(1);
                    end else begin
                        state_d = ST_YELLOW;
                        rem_d   = CNT_W'(YELLOW_T);
                        done_d  = 1'b1;
                    end
                end
                ST_YELLOW: begin
                    if (rem_q > CNT_W'(1)) begin
                        rem_d = rem_q - CNT_W'(1);
                    end else begin
                        state_d = ST_ALLRED;
                        rem_d   = CNT_W'(ALLRED_T);
                        dir_d   = dir_inc_c;
                        done_d  = 1'b1;
                    end
                end
                ST_ALLRED: begin
                    if (rem_q > CNT_W'(1)) begin
                        rem_d = rem_q - CNT_W'(1);
                    end else if (night_mode) begin
                        state_d = ST_FLASH;
                        rem_d   = '0;
                        flash_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_GREEN;
                        rem_d   = CNT_W'(GREEN_T);
                        done_d  = 1'b1;
                    end
                end
                ST_FLASH: begin
                    if (!night_mode) begin
                        state_d = ST_ALLRED;
                        rem_d   = CNT_W'(ALLRED_T);
                        flash_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        flash_d = !flash_q;
                    end
                end
                default: begin
                    state_d = ST_ALLRED;
                    rem_d   = CNT_W'(ALLRED_T);
                end
            endcase
        end
    end

    assign dir_onehot_c = N_DIR'(1) << dir_d;

    // Output decode from the next state so lamps register on the same edge as the phase.
    always_comb begin
        red_d    = '1;
        yellow_d = '0;
        green_d  = '0;
        case (state_d)
            ST_GREEN: begin
                red_d   = ~dir_onehot_c;
                green_d = dir_onehot_c;
            end
            ST_YELLOW: begin
                red_d    = ~dir_onehot_c;
                yellow_d = dir_onehot_c;
            end
            ST_FLASH: begin
                red_d    = '0;
                yellow_d = {N_DIR{flash_d}};
            end
            default: begin
                red_d = '1;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            rem_q    <= CNT_W'(ALLRED_T);
            dir_q    <= '0;
            flash_q  <= 1'b0;
            done_q   <= 1'b0;
            red_q    <= '1;
            yellow_q <= '0;
            green_q  <= '0;
        end else begin
            pre_q    <= pre_d;
            rem_q    <= rem_d;
            dir_q    <= dir_d;
            flash_q  <= flash_d;
            done_q   <= done_d;
            red_q    <= red_d;
            yellow_q <= yellow_d;
            green_q  <= green_d;
        end
    end

    assign red        = red_q;
    assign yellow     = yellow_q;
    assign green      = green_q;
    assign active_dir = dir_q;
    assign remaining  = rem_q;
    assign phase_done = done_q;

endmodule

// File: tb/tb_tl_phase_ctrl.sv
// Directed testbench for tl_phase_ctrl (N_DIR=2 main instance, N_DIR=3 rotation instance).
module tb_tl_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hold;
    logic       night_mode;
    logic [1:0] red, yellow, green;
    logic [0:0] active_dir;
    logic [7:0] remaining;
    logic       phase_done;

    logic       rst_n3;
    logic       hold3;
    logic       night3;
    logic [2:0] red3, yellow3, green3;
    logic [1:0] active_dir3;
    logic [7:0] remaining3;
    logic       phase_done3;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    tl_phase_ctrl #(
        .N_DIR(2), .CNT_W(8), .TICK_DIV(4), .GREEN_T(3), .YELLOW_T(2), .ALLRED_T(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .night_mode(night_mode),
        .red(red), .yellow(yellow), .green(green), .active_dir(active_dir),
        .remaining(remaining), .phase_done(phase_done)
    );

    tl_phase_ctrl #(
        .N_DIR(3), .CNT_W(8), .TICK_DIV(4), .GREEN_T(3), .YELLOW_T(2), .ALLRED_T(1)
    ) dut3 (
        .clk(clk), .rst_n(rst_n3), .hold(hold3), .night_mode(night3),
        .red(red3), .yellow(yellow3), .green(green3), .active_dir(active_dir3),
        .remaining(remaining3), .phase_done(phase_done3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles until the next phase_done pulse of the selected instance (bounded).
    task automatic measure(input bit sel3, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (((sel3 ? phase_done3 : phase_done) !== 1'b1) && n < 200);
    endtask

    initial begin
        int n;
        int multi_green;
        logic [2:0] exp_g3 [4];
        exp_g3[0] = 3'b001; exp_g3[1] = 3'b010; exp_g3[2] = 3'b100; exp_g3[3] = 3'b001;

        rst_n = 1'b0; hold = 1'b0; night_mode = 1'b0;
        rst_n3 = 1'b0; hold3 = 1'b0; night3 = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_red", 32'(red), 32'h3);
        chk("rst_yellow", 32'(yellow), 32'h0);
        chk("rst_green", 32'(green), 32'h0);
        chk("rst_rem", 32'(remaining), 32'd1);
        chk("rst_dir", 32'(active_dir), 32'd0);
        chk("rst_done", 32'(phase_done), 32'd0);

        // 1: initial all-red lasts one tick (4 cycles), then G0
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("init_ar_red", 32'(red), 32'h3);
            chk("init_ar_rem", 32'(remaining), 32'd1);
            chk("init_ar_done", 32'(phase_done), 32'd0);
        end
        step();
        chk("g0_green", 32'(green), 32'h1);
        chk("g0_red", 32'(red), 32'h2);
        chk("g0_rem", 32'(remaining), 32'd3);
        chk("g0_done", 32'(phase_done), 32'd1);

        // 2: free-running rotation, 48-cycle period
        measure(1'b0, n); chk("g0_len", 32'(n), 32'd12);
        chk("y0_yellow", 32'(yellow), 32'h1);
        chk("y0_red", 32'(red), 32'h2);
        chk("y0_rem", 32'(remaining), 32'd2);
        chk("y0_dir", 32'(active_dir), 32'd0);
        measure(1'b0, n); chk("y0_len", 32'(n), 32'd8);
        chk("ar_red", 32'(red), 32'h3);
        chk("ar_dir", 32'(active_dir), 32'd1);
        measure(1'b0, n); chk("ar_len", 32'(n), 32'd4);
        chk("g1_green", 32'(green), 32'h2);
        chk("g1_red", 32'(red), 32'h1);
        measure(1'b0, n); chk("g1_len", 32'(n), 32'd12);
        chk("y1_yellow", 32'(yellow), 32'h2);
        measure(1'b0, n); chk("y1_len", 32'(n), 32'd8);
        chk("ar2_dir", 32'(active_dir), 32'd0);
        measure(1'b0, n); chk("ar2_len", 32'(n), 32'd4);
        chk("g0b_green", 32'(green), 32'h1);

        // 3: hold 10 cycles mid-G0 stretches G0 to 22 cycles
        repeat (5) step();
        chk("pre_hold_rem", 32'(remaining), 32'd2);
        hold = 1'b1;
        repeat (10) step();
        chk("hold_rem", 32'(remaining), 32'd2);
        chk("hold_green", 32'(green), 32'h1);
        chk("hold_done", 32'(phase_done), 32'd0);
        hold = 1'b0;
        measure(1'b0, n); chk("hold_g0_tail", 32'(n), 32'd7);
        chk("hold_y0", 32'(yellow), 32'h1);

        // Run back to the start of G0
        measure(1'b0, n); measure(1'b0, n); measure(1'b0, n); measure(1'b0, n); measure(1'b0, n);
        chk("g0c_green", 32'(green), 32'h1);

        // 4: night mode requested mid-G0; green/yellow not truncated
        repeat (3) step();
        night_mode = 1'b1;
        measure(1'b0, n); chk("night_g0_tail", 32'(n), 32'd9);
        chk("night_y0", 32'(yellow), 32'h1);
        measure(1'b0, n); chk("night_y0_len", 32'(n), 32'd8);
        chk("night_ar", 32'(red), 32'h3);
        measure(1'b0, n); chk("night_ar_len", 32'(n), 32'd4);
        chk("flash_yellow_on", 32'(yellow), 32'h3);
        chk("flash_red", 32'(red), 32'h0);
        chk("flash_green", 32'(green), 32'h0);
        chk("flash_rem", 32'(remaining), 32'd0);
        repeat (3) step();
        chk("flash_hold_on", 32'(yellow), 32'h3);
        step();
        chk("flash_off", 32'(yellow), 32'h0);
        chk("flash_off_red", 32'(red), 32'h0);
        repeat (4) step();
        chk("flash_on2", 32'(yellow), 32'h3);
        night_mode = 1'b0;
        measure(1'b0, n); chk("flash_exit_len", 32'(n), 32'd4);
        chk("exit_ar_red", 32'(red), 32'h3);
        chk("exit_ar_yellow", 32'(yellow), 32'h0);
        chk("exit_ar_rem", 32'(remaining), 32'd1);
        measure(1'b0, n); chk("exit_ar_len", 32'(n), 32'd4);
        chk("exit_green", 32'(green), 32'h2);
        chk("exit_dir", 32'(active_dir), 32'd1);

        // 5: asynchronous reset mid-Y1
        measure(1'b0, n);
        chk("y1b_yellow", 32'(yellow), 32'h2);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_red", 32'(red), 32'h3);
        chk("arst_yellow", 32'(yellow), 32'h0);
        chk("arst_rem", 32'(remaining), 32'd1);
        chk("arst_dir", 32'(active_dir), 32'd0);
        chk("arst_done", 32'(phase_done), 32'd0);

        // 6: N_DIR=3 rotation order, never two greens
        rst_n3 = 1'b1;
        repeat (4) step();
        chk("n3_g_0", 32'(green3), 32'(exp_g3[0]));
        chk("n3_dir_0", 32'(active_dir3), 32'd0);
        multi_green = 0;
        for (int k = 1; k < 4; k++) begin
            for (int c = 0; c < 24; c++) begin
                step();
                if ($countones(green3) > 1) multi_green++;
            end
            chk($sformatf("n3_g_%0d", k), 32'(green3), 32'(exp_g3[k]));
            chk($sformatf("n3_dir_%0d", k), 32'(active_dir3), 32'(k % 3));
            chk($sformatf("n3_done_%0d", k), 32'(phase_done3), 32'd1);
        end
        chk("n3_single_green", 32'(multi_green), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
